cs_sequencer: RTL and testbench

- Command-driven controller that sits directly upstream of the computation storage interface and drives all of its control signals.
- Accepts one command {addA, addB, addC, op} over a valid/ready handshake.
- Reads operand A through RD_en1 and operand B through RD_en2 on the shared DQ bus, computes the selected operation, writes the result to addC through WR_en1, then pulses seq_finished.
- Owns the DQ tri-state driver.

---
 rtl/cs_pkg.sv | 25 ++
 rtl/cs_sequencer_if.sv | 29 ++
 rtl/cs_alu.sv | 45 ++++
 rtl/cs_sequencer.sv | 151 +++++++++++++++
 tb/tb_cs_sequencer.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cs_pkg.sv
// Shared types for the computation-storage sequencer: FSM state and ALU op encodings.
// Default sizing constants live here so the interface, ALU and top all agree.
package cs_pkg;

  localparam int DEF_MEM_WIDTH     = 8;
  localparam int DEF_MEM_DEPTH     = 16;
  localparam int DEF_NO_OPERATIONS = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    EXEC = 3'd3,
    WR_C = 3'd4,
    DONE = 3'd5
  } cs_state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_XOR = 2'd3
  } cs_op_e;

endpackage

// File: rtl/cs_sequencer_if.sv
// Command handshake between a command issuer (master) and the sequencer (slave).
interface cs_sequencer_if
  import cs_pkg::*;
#(
  parameter int MEM_DEPTH     = DEF_MEM_DEPTH,
  parameter int NO_OPERATIONS = DEF_NO_OPERATIONS
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int OW = $clog2(NO_OPERATIONS);

  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addA;
  logic [AW-1:0] cmd_addB;
  logic [AW-1:0] cmd_addC;
  logic [OW-1:0] cmd_op;

  modport master (
    output cmd_valid, cmd_addA, cmd_addB, cmd_addC, cmd_op,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_addA, cmd_addB, cmd_addC, cmd_op,
    output cmd_ready
  );

endinterface

// File: rtl/cs_alu.sv
// Combinational ALU: ADD, SUB (a-b), AND, XOR; unknown codes give 0. Results wrap.
// With CS_STATUS_EN defined it also reports carry (ADD) / borrow (SUB).
module cs_alu
  import cs_pkg::*;
#(
  parameter int MEM_WIDTH = DEF_MEM_WIDTH,
  parameter int OW        = 2
) (
  input  logic [MEM_WIDTH-1:0] a,
  input  logic [MEM_WIDTH-1:0] b,
  input  logic [OW-1:0]        op,
`ifdef CS_STATUS_EN
  output logic                 carry,
`endif
  output logic [MEM_WIDTH-1:0] result
);

`ifdef CS_STATUS_EN
  localparam int EXT_W = MEM_WIDTH + 1;
`else
  localparam int EXT_W = MEM_WIDTH;
`endif

  // One extra bit in the status build holds the ADD carry / SUB borrow
  logic [EXT_W-1:0] ext;

  always_comb begin
    ext = '0;
    case (op)
      OW'(OP_ADD): ext = EXT_W'(a) + EXT_W'(b);
      OW'(OP_SUB): ext = EXT_W'(a) - EXT_W'(b);
      OW'(OP_AND): ext = EXT_W'(a & b);
      OW'(OP_XOR): ext = EXT_W'(a ^ b);
      default:     ext = '0;
    endcase
    result = ext[MEM_WIDTH-1:0];
`ifdef CS_STATUS_EN
    carry = 1'b0;
    if (op == OW'(OP_ADD) || op == OW'(OP_SUB)) begin
      carry = ext[EXT_W-1];
    end
`endif
  end

endmodule

// File: rtl/cs_sequencer.sv
// Command sequencer for the computation storage: read A, read B, compute, write C, finish.
// Optional status outputs (carry, zero, illegal_op) are built when CS_STATUS_EN is defined.
module cs_sequencer
  import cs_pkg::*;
#(
  parameter  int MEM_WIDTH     = DEF_MEM_WIDTH,
  parameter  int MEM_DEPTH     = DEF_MEM_DEPTH,
  parameter  int NO_OPERATIONS = DEF_NO_OPERATIONS,
  localparam int AW            = $clog2(MEM_DEPTH),
  localparam int OW            = $clog2(NO_OPERATIONS)
) (
  input  logic                 clk,
  input  logic                 rst,
  cs_sequencer_if.slave        cmd,
  output logic [AW-1:0]        addA,
  output logic [AW-1:0]        addB,
  output logic [AW-1:0]        addC,
  output logic [OW-1:0]        operation_select,
  output logic                 RD_en1,
  output logic                 RD_en2,
  output logic                 WR_en1,
  inout  wire  [MEM_WIDTH-1:0] DQ,
  output logic                 seq_finished,
`ifdef CS_STATUS_EN
  output logic                 carry,
  output logic                 zero,
  output logic                 illegal_op,
`endif
  output logic                 busy
);

  cs_state_e state, state_next;

  logic                 ready;
  logic                 accept;
  logic [MEM_WIDTH-1:0] opA;
  logic [MEM_WIDTH-1:0] opB;
  logic [MEM_WIDTH-1:0] result;
  logic [MEM_WIDTH-1:0] alu_result;
`ifdef CS_STATUS_EN
  logic                 alu_carry;
`endif

  assign cmd.cmd_ready = ready;
  assign accept        = ready & cmd.cmd_valid;

  // Only this block drives the bus, and only while writing the result back
  assign DQ = WR_en1 ? result : {MEM_WIDTH{1'bz}};

  cs_alu #(
    .MEM_WIDTH (MEM_WIDTH),
    .OW        (OW)
  ) u_alu (
    .a      (opA),
    .b      (opB),
    .op     (operation_select),
`ifdef CS_STATUS_EN
    .carry  (alu_carry),
`endif
    .result (alu_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    ready        = 1'b0;
    busy         = 1'b1;
    RD_en1       = 1'b0;
    RD_en2       = 1'b0;
    WR_en1       = 1'b0;
    seq_finished = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
        if (cmd.cmd_valid) begin
          state_next = RD_A;
        end
      end
      RD_A: begin
        RD_en1     = 1'b1;
        state_next = RD_B;
      end
      RD_B: begin
        RD_en2     = 1'b1;
        state_next = EXEC;
      end
      EXEC: begin
        state_next = WR_C;
      end
      WR_C: begin
        WR_en1     = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        seq_finished = 1'b1;
        state_next   = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Addresses stay registered from accept until the next accept, so memory sees them stable
  always_ff @(posedge clk) begin
    if (rst) begin
      addA             <= '0;
      addB             <= '0;
      addC             <= '0;
      operation_select <= '0;
      opA              <= '0;
      opB              <= '0;
      result           <= '0;
`ifdef CS_STATUS_EN
      carry            <= 1'b0;
      zero             <= 1'b0;
      illegal_op       <= 1'b0;
`endif
    end else begin
      if (accept) begin
        addA             <= cmd.cmd_addA;
        addB             <= cmd.cmd_addB;
        addC             <= cmd.cmd_addC;
        operation_select <= cmd.cmd_op;
      end
      if (RD_en1) begin
        opA <= DQ;
      end
      if (RD_en2) begin
        opB <= DQ;
      end
      if (state == EXEC) begin
        result     <= alu_result;
`ifdef CS_STATUS_EN
        carry      <= alu_carry;
        zero       <= (alu_result == '0);
        illegal_op <= (32'(operation_select) >= 32'd4);
`endif
      end
    end
  end

endmodule

// File: tb/tb_cs_sequencer.sv
// Self-checking bench for cs_sequencer: table-driven commands with a write scoreboard,
// plus busy-gating and reset-abort sequences. Status outputs checked when CS_STATUS_EN is defined.
module tb_cs_sequencer;
  import cs_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] addA, addB, addC;
  logic [1:0] operation_select;
  logic       RD_en1, RD_en2, WR_en1;
  logic       seq_finished, busy;
  wire  [7:0] DQ;
`ifdef CS_STATUS_EN
  logic       carry, zero, illegal_op;
`endif

  logic [7:0] mem [16];

  typedef struct {
    logic [3:0] a, b, c;
    logic [1:0] op;
    logic [7:0] da, db, res;
    logic       cy, zr;
  } vec_t;

  typedef struct {
    logic [3:0] c;
    logic [7:0] d;
  } sb_t;

  vec_t vecs[8];
  sb_t  sbq[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  cs_sequencer_if #(.MEM_DEPTH(16), .NO_OPERATIONS(4)) cif ();

  cs_sequencer #(.MEM_WIDTH(8), .MEM_DEPTH(16), .NO_OPERATIONS(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .cmd              (cif),
    .addA             (addA),
    .addB             (addB),
    .addC             (addC),
    .operation_select (operation_select),
    .RD_en1           (RD_en1),
    .RD_en2           (RD_en2),
    .WR_en1           (WR_en1),
    .DQ               (DQ),
    .seq_finished     (seq_finished),
`ifdef CS_STATUS_EN
    .carry            (carry),
    .zero             (zero),
    .illegal_op       (illegal_op),
`endif
    .busy             (busy)
  );

  // Memory model: read data appears on DQ in the same cycle as the strobe
  assign DQ = RD_en1 ? mem[addA] : (RD_en2 ? mem[addB] : 8'bz);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic handleWrite(input string tag);
    sb_t e;
    if (WR_en1) begin
      if (sbq.size() == 0) begin
        check({tag, "_sb_unexpected_write"}, 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        check({tag, "_wr_addr"}, 32'(addC), 32'(e.c));
        check({tag, "_wr_data"}, 32'(DQ), 32'(e.d));
      end
      mem[addC] = DQ;
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    int guard;
    mem[v.a] = v.da;
    mem[v.b] = v.db;
    @(negedge clk);
    cif.cmd_addA  = v.a;
    cif.cmd_addB  = v.b;
    cif.cmd_addC  = v.c;
    cif.cmd_op    = v.op;
    cif.cmd_valid = 1'b1;
    guard = 0;
    while (!cif.cmd_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_ready_at_accept"}, 32'(cif.cmd_ready), 32'd1);
    sbq.push_back('{c: v.c, d: v.res});
    @(negedge clk);
    cif.cmd_valid = 1'b0;
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    bit fin;
    fin = 1'b0;
    for (int cyc = 1; cyc <= 8 && !fin; cyc++) begin
      if (cyc > 1) @(negedge clk);
      check({tag, "_strobe_excl"}, 32'(RD_en1) + 32'(RD_en2) + 32'(WR_en1) <= 1, 32'd1);
      check({tag, "_busy"}, 32'(busy), 32'(cyc <= 5));
      check({tag, "_rd1"}, 32'(RD_en1), 32'(cyc == 1));
      check({tag, "_rd2"}, 32'(RD_en2), 32'(cyc == 2));
      check({tag, "_wr"}, 32'(WR_en1), 32'(cyc == 4));
      check({tag, "_fin"}, 32'(seq_finished), 32'(cyc == 5));
      handleWrite(tag);
      if (seq_finished) fin = 1'b1;
    end
    check({tag, "_fin_seen"}, 32'(fin), 32'd1);
    check({tag, "_mem_result"}, 32'(mem[v.c]), 32'(v.res));
`ifdef CS_STATUS_EN
    check({tag, "_carry"}, 32'(carry), 32'(v.cy));
    check({tag, "_zero"}, 32'(zero), 32'(v.zr));
    check({tag, "_illegal_op"}, 32'(illegal_op), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t rv;
    int   hs, t1, t2, fins, wr_cnt;

    //            a      b      c      op     da     db     res     cy    zr
    vecs[0] = '{4'd2,  4'd5,  4'd9,  2'd0, 8'h30, 8'h12, 8'h42, 1'b0, 1'b0};
    vecs[1] = '{4'd1,  4'd3,  4'd1,  2'd1, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{4'd4,  4'd6,  4'd7,  2'd2, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b1};
    vecs[3] = '{4'd8,  4'd8,  4'd10, 2'd3, 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1};
    vecs[4] = '{4'd14, 4'd0,  4'd15, 2'd3, 8'h3C, 8'hA5, 8'h99, 1'b0, 1'b0};
    vecs[5] = '{4'd0,  4'd15, 4'd2,  2'd2, 8'hC3, 8'h5F, 8'h43, 1'b0, 1'b0};
    vecs[6] = '{4'd3,  4'd4,  4'd5,  2'd1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0};
    vecs[7] = '{4'd11, 4'd12, 4'd13, 2'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};

    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    cif.cmd_valid = 1'b0;
    cif.cmd_addA  = '0;
    cif.cmd_addB  = '0;
    cif.cmd_addC  = '0;
    cif.cmd_op    = '0;
    rst = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rd1", 32'(RD_en1), 32'd0);
    check("rst_rd2", 32'(RD_en2), 32'd0);
    check("rst_wr", 32'(WR_en1), 32'd0);
    check("rst_fin", 32'(seq_finished), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(cif.cmd_ready), 32'd1);
    check("rst_addr", {20'd0, addA, addB, addC}, 32'd0);
    check("rst_op", 32'(operation_select), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(cif.cmd_ready), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);

    // Table-driven commands
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], $sformatf("v%0d", i));
      checkOutput(vecs[i], $sformatf("v%0d", i));
    end

    // Reset asserted during EXEC of an XOR: no write, back to IDLE
    rv = '{4'd1, 4'd2, 4'd3, 2'd3, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0};
    mem[3] = 8'h77;
    applyStimulus(rv, "rstmid");
    @(negedge clk);
    @(negedge clk);
    check("rstmid_exec_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_idle_ready", 32'(cif.cmd_ready), 32'd1);
    check("rstmid_idle_busy", 32'(busy), 32'd0);
    check("rstmid_addA_clr", 32'(addA), 32'd0);
`ifdef CS_STATUS_EN
    check("rstmid_carry_clr", 32'(carry), 32'd0);
    check("rstmid_zero_clr", 32'(zero), 32'd0);
`endif
    rst = 1'b0;
    sbq.delete();
    wr_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (WR_en1) wr_cnt++;
      @(negedge clk);
    end
    check("rstmid_no_write", 32'(wr_cnt), 32'd0);
    check("rstmid_dest_kept", 32'(mem[3]), 32'h77);

    // Busy gating: cmd_valid held high for 12 cycles, fields changed after first accept
    mem[2] = 8'h30; mem[5] = 8'h12; mem[9] = 8'h00;
    mem[11] = 8'h0F; mem[12] = 8'hF0; mem[13] = 8'h00;
    hs = 0; t1 = -1; t2 = -1; fins = 0;
    @(negedge clk);
    cif.cmd_addA = 4'd2; cif.cmd_addB = 4'd5; cif.cmd_addC = 4'd9; cif.cmd_op = 2'd0;
    cif.cmd_valid = 1'b1;
    for (int t = 0; t < 12; t++) begin
      if (t > 0) @(negedge clk);
      handleWrite("gate");
      if (seq_finished) fins++;
      if (t >= 1 && t <= 6) check($sformatf("gate_hold_addA_t%0d", t), 32'(addA), 32'd2);
      if (t == 7) check("gate_second_addA", 32'(addA), 32'd11);
      if (cif.cmd_valid && cif.cmd_ready) begin
        hs++;
        if (hs == 1) begin
          t1 = t;
          sbq.push_back('{c: 4'd9, d: 8'h42});
        end else begin
          t2 = t;
          sbq.push_back('{c: 4'd13, d: 8'hFF});
        end
      end
      if (t == 1) begin
        cif.cmd_addA = 4'd11; cif.cmd_addB = 4'd12; cif.cmd_addC = 4'd13; cif.cmd_op = 2'd3;
      end
    end
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    check("gate_handshakes", 32'(hs), 32'd2);
    check("gate_spacing", 32'(t2 - t1), 32'd6);
    check("gate_fin_pulses", 32'(fins), 32'd2);
    check("gate_mem9", 32'(mem[9]), 32'h42);
    check("gate_mem13", 32'(mem[13]), 32'hFF);
    check("sb_empty", 32'(sbq.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
